ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Multi-cycle hardwired control unit for the 32-bit RISC datapath.
- Reads the instruction register and the CON flip-flop.
- Each cycle it drives the full set of datapath strobes (register enables, bus-source selects, Gra/Grb/Grc, Rin/Rout, memory Read/Write) through fetch and execute T-steps.
- Sits between the top level and the datapath; it is the initiator of every datapath control input.

Parameters:
- IR_W, 32, instruction register width
- OP_LSB, 27, bit position of the opcode LSB; opcode is IR[OP_LSB+4:OP_LSB]
- NCTL, 27, width of the control bundle

Ports:
- clk  input  1  system clock; all state changes on rising edge
- clr  input  1  asynchronous, active-low reset
- IR  input  IR_W  current instruction register contents
- CON_FF  input  1  branch condition flag from the datapath
- Stop  input  1  halt request, sampled at the last step of each instruction
- ctrl  output  NCTL  datapath control bundle; bit map in the package
- step  output  3  current T-step, 0..7, for debug
- run  output  1  high while sequencing; low in RESET and HALT

Behaviour:
- Reset and timing:
  - clr low forces state RESET, step=0, ctrl=0 and run=0 immediately, including mid-instruction.
  - First rising edge with clr high: RESET -> FETCH, step=0.
  - Registered state is {mode, step}; mode is RESET, FETCH, EXEC or HALT.
  - ctrl is combinational decode of {mode, step, opcode, CON_FF}; the datapath samples it on the next clk edge.
- Fetch (every instruction):
  - T0: PCout, MAR_enable, IncPC, Z_enable.
  - T1: ZLowout, IncPC, PC_enable, Read, MDR_enable.
  - T2: MDRout, IR_enable. Then mode=EXEC, step=3.
- Execute: the opcode is decoded from IR at T3 and later.
  - R-ALU (00011..01011): T3 Grb,Rout,Y_enable; T4 Grc,Rout,Z_enable; T5 ZLowout,Gra,Rin.
  - Immediate (01100..01110): T3 Grb,Rout,Y_enable; T4 Cout,Z_enable; T5 ZLowout,Gra,Rin.
  - mul/div (01111,10000): T3 Gra,Rout,Y_enable; T4 Grb,Rout,Z_enable; T5 ZLowout,LO_enable; T6 ZHighout,HI_enable.
  - neg/not (10001,10010): T3 Grb,Rout,Z_enable; T4 ZLowout,Gra,Rin.
  - ld (00000): T3 Grb,BAout,Y_enable; T4 Cout,Z_enable; T5 ZLowout,MAR_enable; T6 Read,MDR_enable; T7 MDRout,Gra,Rin.
  - ldi (00001): T3 Grb,BAout,Y_enable; T4 Cout,Z_enable; T5 ZLowout,Gra,Rin.
  - st (00010): T3 Grb,BAout,Y_enable; T4 Cout,Z_enable; T5 ZLowout,MAR_enable; T6 Gra,Rout,MDR_enable (Read=0); T7 Write.
  - br (10011): T3 Gra,Rout,CONin; T4 PCout,Y_enable; T5 Cout,Z_enable; T6 ZLowout,PC_enable only if CON_FF=1, otherwise ctrl=0.
  - jr (10100): T3 Gra,Rout,PC_enable.
  - in (10110): T3 InPortout,Gra,Rin. out (10111): T3 Gra,Rout,OutPort_enable.
  - mfhi (11000): T3 HIout,Gra,Rin. mflo (11001): T3 LOout,Gra,Rin.
  - nop (11010), jal (10101) and undefined opcodes: T3 with ctrl=0.
  - halt (11011): T3 with ctrl=0, then mode=HALT.
- After the last step:
  - mode=HALT if Stop=1 or the opcode is halt; otherwise FETCH, step=0.
  - HALT: ctrl=0, run=0, held until clr.
- Exclusivity: at most one bus-source bit (PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, Rout, BAout) is high in any cycle; the bench asserts this.
- Instruction latency (cycles, including fetch): R-ALU/imm/ldi 6, mul/div 7, neg/not 5, ld/st 8, br 7, single-step ops 4.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_LD..OP_HALT)
  - mode encoding
  - ctrl bit indices: 0 Read, 1 Write, 2 IncPC, 3 PC_enable, 4 Z_enable, 5 MDR_enable, 6 MAR_enable, 7 Y_enable, 8 HI_enable, 9 LO_enable, 10 IR_enable, 11 OutPort_enable, 12 PCout, 13 ZHighout, 14 ZLowout, 15 HIout, 16 LOout, 17 MDRout, 18 InPortout, 19 Cout, 20 BAout, 21 CONin, 22 Gra, 23 Grb, 24 Grc, 25 Rin, 26 Rout
- One sub-module, ctrl_decode: purely combinational {mode, step, opcode, CON_FF} -> ctrl and last_step.
- ctrl_sequencer keeps the registers and next-state logic.

Test Plan:
- Reset: clr=0, then release. Required: ctrl=0 and run=0 during reset; first cycle after release step=0 with ctrl bits 12, 6, 2, 4 set; run=1.
- Add: IR=0x1A920000 (add r5,r2,r4), Stop=0. Required: T3 asserts Grb,Rout,Y_enable; T4 Grc,Rout,Z_enable; T5 ZLowout,Gra,Rin; next cycle step=0 (6 cycles total).
- ld/st: IR opcode 00000. Required: Read=1 at T1 and T6, MDRout,Rin at T7. Opcode 00010: Write=1 only at T7, Read=0 at T6, 8 cycles each.
- Branch: opcode 10011 with CON_FF=1. Required: PC_enable=1 at T6. Repeat with CON_FF=0: ctrl=0 at T6; both return to step 0 after T6.
- Halt/Stop: IR=0xD8000000. Required: run=0 from the cycle after T3, ctrl=0 held for 20 cycles. Separately, Stop=1 during add T5 causes HALT instead of fetch.
- Reset mid-instruction: clr pulsed low during ld T5. Required: ctrl=0 asynchronously (before the next edge); restart at fetch T0 after release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, sequencer
// modes, control-bundle bit positions and opcode classification helpers.
package cpu_ctrl_pkg;

  // Opcodes (IR[31:27] with the default field placement)
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // Sequencer mode
  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_FETCH,
    MODE_EXEC,
    MODE_HALT
  } mode_t;

  // Control bundle bit positions
  localparam int unsigned B_READ     = 0;
  localparam int unsigned B_WRITE    = 1;
  localparam int unsigned B_INCPC    = 2;
  localparam int unsigned B_PC_EN    = 3;
  localparam int unsigned B_Z_EN     = 4;
  localparam int unsigned B_MDR_EN   = 5;
  localparam int unsigned B_MAR_EN   = 6;
  localparam int unsigned B_Y_EN     = 7;
  localparam int unsigned B_HI_EN    = 8;
  localparam int unsigned B_LO_EN    = 9;
  localparam int unsigned B_IR_EN    = 10;
  localparam int unsigned B_OUTP_EN  = 11;
  localparam int unsigned B_PCOUT    = 12;
  localparam int unsigned B_ZHIGHOUT = 13;
  localparam int unsigned B_ZLOWOUT  = 14;
  localparam int unsigned B_HIOUT    = 15;
  localparam int unsigned B_LOOUT    = 16;
  localparam int unsigned B_MDROUT   = 17;
  localparam int unsigned B_INPOUT   = 18;
  localparam int unsigned B_COUT     = 19;
  localparam int unsigned B_BAOUT    = 20;
  localparam int unsigned B_CONIN    = 21;
  localparam int unsigned B_GRA      = 22;
  localparam int unsigned B_GRB      = 23;
  localparam int unsigned B_GRC      = 24;
  localparam int unsigned B_RIN      = 25;
  localparam int unsigned B_ROUT     = 26;

  // Instruction families sharing one execute sequence
  typedef enum logic [3:0] {
    CL_RALU,
    CL_IMM,
    CL_MULDIV,
    CL_UNARY,
    CL_LD,
    CL_LDI,
    CL_ST,
    CL_BR,
    CL_JR,
    CL_IN,
    CL_OUT,
    CL_MFHI,
    CL_MFLO,
    CL_HALT,
    CL_NONE
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    c = CL_NONE;
    if (op inside {[OP_ADD:OP_ROL]})        c = CL_RALU;
    else if (op inside {[OP_ADDI:OP_ORI]})  c = CL_IMM;
    else if (op inside {OP_MUL, OP_DIV})    c = CL_MULDIV;
    else if (op inside {OP_NEG, OP_NOT})    c = CL_UNARY;
    else begin
      case (op)
        OP_LD:   c = CL_LD;
        OP_LDI:  c = CL_LDI;
        OP_ST:   c = CL_ST;
        OP_BR:   c = CL_BR;
        OP_JR:   c = CL_JR;
        OP_IN:   c = CL_IN;
        OP_OUT:  c = CL_OUT;
        OP_MFHI: c = CL_MFHI;
        OP_MFLO: c = CL_MFLO;
        OP_HALT: c = CL_HALT;
        default: c = CL_NONE;  // nop, jal, undefined
      endcase
    end
    return c;
  endfunction

  // Final T-step of the execute phase for each family
  function automatic logic [2:0] last_step_of(input op_class_t c);
    logic [2:0] s;
    case (c)
      CL_RALU, CL_IMM, CL_LDI: s = 3'd5;
      CL_MULDIV, CL_BR:        s = 3'd6;
      CL_UNARY:                s = 3'd4;
      CL_LD, CL_ST:            s = 3'd7;
      default:                 s = 3'd3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction/flag inputs, control strobes
// and debug status. The sequencer is the master.
interface ctrl_sequencer_if #(
  parameter int IR_W = 32,
  parameter int NCTL = 27
);
  logic [IR_W-1:0] IR;
  logic            CON_FF;
  logic            Stop;
  logic [NCTL-1:0] ctrl;
  logic [2:0]      step;
  logic            run;

  modport master (
    input  IR, CON_FF, Stop,
    output ctrl, step, run
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  ctrl, step, run
  );
endinterface

// File: rtl/ctrl_sequencer_decode.sv
// Combinational decode of {mode, step, opcode, CON_FF} into the datapath
// control bundle, plus the flag marking the final step of an instruction.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int NCTL = 27
) (
  input  mode_t           mode,
  input  logic [2:0]      step,
  input  logic [4:0]      opcode,
  input  logic            con_ff,
  output logic [NCTL-1:0] ctrl,
  output logic            last_step
);

  op_class_t cls;
  assign cls = op_class(opcode);

  // Strobe decode; all strobes default low so RESET/HALT drive nothing
  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    case (mode)
      MODE_FETCH: begin
        case (step)
          3'd0: begin
            ctrl[B_PCOUT] = 1'b1; ctrl[B_MAR_EN] = 1'b1;
            ctrl[B_INCPC] = 1'b1; ctrl[B_Z_EN]   = 1'b1;
          end
          3'd1: begin
            ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_INCPC]  = 1'b1; ctrl[B_PC_EN] = 1'b1;
            ctrl[B_READ]    = 1'b1; ctrl[B_MDR_EN] = 1'b1;
          end
          3'd2: begin
            ctrl[B_MDROUT] = 1'b1; ctrl[B_IR_EN] = 1'b1;
          end
          default: ;
        endcase
      end
      MODE_EXEC: begin
        last_step = (step == last_step_of(cls));
        case (cls)
          CL_RALU, CL_IMM: begin
            case (step)
              3'd3: begin ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_Y_EN] = 1'b1; end
              3'd4: begin
                if (cls == CL_RALU) begin
                  ctrl[B_GRC] = 1'b1; ctrl[B_ROUT] = 1'b1;
                end else begin
                  ctrl[B_COUT] = 1'b1;
                end
                ctrl[B_Z_EN] = 1'b1;
              end
              3'd5: begin ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1; end
              default: ;
            endcase
          end
          CL_MULDIV: begin
            case (step)
              3'd3: begin ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_Y_EN] = 1'b1; end
              3'd4: begin ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_Z_EN] = 1'b1; end
              3'd5: begin ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_LO_EN] = 1'b1; end
              3'd6: begin ctrl[B_ZHIGHOUT] = 1'b1; ctrl[B_HI_EN] = 1'b1; end
              default: ;
            endcase
          end
          CL_UNARY: begin
            case (step)
              3'd3: begin ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_Z_EN] = 1'b1; end
              3'd4: begin ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1; end
              default: ;
            endcase
          end
          // ld/ldi/st share the effective-address computation in T3..T4
          CL_LD, CL_LDI, CL_ST: begin
            case (step)
              3'd3: begin ctrl[B_GRB] = 1'b1; ctrl[B_BAOUT] = 1'b1; ctrl[B_Y_EN] = 1'b1; end
              3'd4: begin ctrl[B_COUT] = 1'b1; ctrl[B_Z_EN] = 1'b1; end
              3'd5: begin
                ctrl[B_ZLOWOUT] = 1'b1;
                if (cls == CL_LDI) begin
                  ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                end else begin
                  ctrl[B_MAR_EN] = 1'b1;
                end
              end
              3'd6: begin
                if (cls == CL_LD) begin
                  ctrl[B_READ] = 1'b1; ctrl[B_MDR_EN] = 1'b1;
                end else if (cls == CL_ST) begin
                  ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_MDR_EN] = 1'b1;
                end
              end
              3'd7: begin
                if (cls == CL_LD) begin
                  ctrl[B_MDROUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                end else if (cls == CL_ST) begin
                  ctrl[B_WRITE] = 1'b1;
                end
              end
              default: ;
            endcase
          end
          CL_BR: begin
            case (step)
              3'd3: begin ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_CONIN] = 1'b1; end
              3'd4: begin ctrl[B_PCOUT] = 1'b1; ctrl[B_Y_EN] = 1'b1; end
              3'd5: begin ctrl[B_COUT] = 1'b1; ctrl[B_Z_EN] = 1'b1; end
              3'd6: begin
                if (con_ff) begin
                  ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_PC_EN] = 1'b1;
                end
              end
              default: ;
            endcase
          end
          CL_JR: if (step == 3'd3) begin
            ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_PC_EN] = 1'b1;
          end
          CL_IN: if (step == 3'd3) begin
            ctrl[B_INPOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
          end
          CL_OUT: if (step == 3'd3) begin
            ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_OUTP_EN] = 1'b1;
          end
          CL_MFHI: if (step == 3'd3) begin
            ctrl[B_HIOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
          end
          CL_MFLO: if (step == 3'd3) begin
            ctrl[B_LOOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
          end
          default: ;  // nop, jal, halt, undefined: one idle step
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle hardwired control unit: holds {mode, step} and advances
// through fetch and execute T-steps; strobes come from ctrl_decode.
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int OP_LSB = 27,
  parameter int NCTL   = 27
) (
  input logic               clk,
  input logic               clr,
  ctrl_sequencer_if.master  bus
);

  if (OP_LSB + 5 > IR_W) begin : g_bad_opcode_field
    $error("opcode field does not fit in IR");
  end

  mode_t           mode;
  logic [2:0]      step;
  logic [4:0]      opcode;
  logic [NCTL-1:0] ctrl_d;
  logic            last_step;
  logic            halt_req;

  assign opcode   = bus.IR[OP_LSB+4:OP_LSB];
  assign halt_req = bus.Stop || (opcode == OP_HALT);

  ctrl_decode #(
    .NCTL (NCTL)
  ) u_decode (
    .mode      (mode),
    .step      (step),
    .opcode    (opcode),
    .con_ff    (bus.CON_FF),
    .ctrl      (ctrl_d),
    .last_step (last_step)
  );

  // Mode/step sequencing; clr low returns to RESET immediately
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mode <= MODE_RESET;
      step <= '0;
    end else begin
      case (mode)
        MODE_RESET: begin
          mode <= MODE_FETCH;
          step <= '0;
        end
        MODE_FETCH: begin
          if (step == 3'd2) begin
            mode <= MODE_EXEC;
            step <= 3'd3;
          end else begin
            step <= step + 3'd1;
          end
        end
        MODE_EXEC: begin
          if (last_step) begin
            mode <= halt_req ? MODE_HALT : MODE_FETCH;
            step <= '0;
          end else begin
            step <= step + 3'd1;
          end
        end
        MODE_HALT: begin
          mode <= MODE_HALT;
          step <= '0;
        end
        default: begin
          mode <= MODE_RESET;
          step <= '0;
        end
      endcase
    end
  end

  assign bus.ctrl = ctrl_d;
  assign bus.step = step;
  assign bus.run  = (mode == MODE_FETCH) || (mode == MODE_EXEC);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: per-instruction strobe-list model checked
// every cycle, plus directed literal expectations.
module tb_ctrl_sequencer;

  localparam logic [26:0] READ   = 27'h1 << 0;
  localparam logic [26:0] WRITE  = 27'h1 << 1;
  localparam logic [26:0] INCPC  = 27'h1 << 2;
  localparam logic [26:0] PCEN   = 27'h1 << 3;
  localparam logic [26:0] ZEN    = 27'h1 << 4;
  localparam logic [26:0] MDREN  = 27'h1 << 5;
  localparam logic [26:0] MAREN  = 27'h1 << 6;
  localparam logic [26:0] YEN    = 27'h1 << 7;
  localparam logic [26:0] HIEN   = 27'h1 << 8;
  localparam logic [26:0] LOEN   = 27'h1 << 9;
  localparam logic [26:0] IREN   = 27'h1 << 10;
  localparam logic [26:0] OUTEN  = 27'h1 << 11;
  localparam logic [26:0] PCOUT  = 27'h1 << 12;
  localparam logic [26:0] ZHI    = 27'h1 << 13;
  localparam logic [26:0] ZLO    = 27'h1 << 14;
  localparam logic [26:0] HIOUT  = 27'h1 << 15;
  localparam logic [26:0] LOOUT  = 27'h1 << 16;
  localparam logic [26:0] MDROUT = 27'h1 << 17;
  localparam logic [26:0] INPOUT = 27'h1 << 18;
  localparam logic [26:0] COUT   = 27'h1 << 19;
  localparam logic [26:0] BAOUT  = 27'h1 << 20;
  localparam logic [26:0] CONIN  = 27'h1 << 21;
  localparam logic [26:0] GRA    = 27'h1 << 22;
  localparam logic [26:0] GRB    = 27'h1 << 23;
  localparam logic [26:0] GRC    = 27'h1 << 24;
  localparam logic [26:0] RIN    = 27'h1 << 25;
  localparam logic [26:0] ROUT   = 27'h1 << 26;
  localparam logic [26:0] SRC_MASK = PCOUT | ZHI | ZLO | HIOUT | LOOUT |
                                     MDROUT | INPOUT | COUT | ROUT | BAOUT;

  typedef logic [26:0] wq_t[$];

  logic clk;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  ctrl_sequencer_if bus ();

  ctrl_sequencer #(
    .IR_W   (32),
    .OP_LSB (27),
    .NCTL   (27)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full strobe list of one instruction, one word per cycle from T0
  function automatic wq_t seq_of(input logic [4:0] op, input logic con);
    wq_t q;
    q = {};
    q.push_back(PCOUT | MAREN | INCPC | ZEN);
    q.push_back(ZLO | INCPC | PCEN | READ | MDREN);
    q.push_back(MDROUT | IREN);
    if (op >= 5'd3 && op <= 5'd11) begin
      q.push_back(GRB | ROUT | YEN); q.push_back(GRC | ROUT | ZEN); q.push_back(ZLO | GRA | RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      q.push_back(GRB | ROUT | YEN); q.push_back(COUT | ZEN); q.push_back(ZLO | GRA | RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(GRA | ROUT | YEN); q.push_back(GRB | ROUT | ZEN);
      q.push_back(ZLO | LOEN); q.push_back(ZHI | HIEN);
    end else if (op == 5'd17 || op == 5'd18) begin
      q.push_back(GRB | ROUT | ZEN); q.push_back(ZLO | GRA | RIN);
    end else begin
      case (op)
        5'd0: begin
          q.push_back(GRB | BAOUT | YEN); q.push_back(COUT | ZEN); q.push_back(ZLO | MAREN);
          q.push_back(READ | MDREN); q.push_back(MDROUT | GRA | RIN);
        end
        5'd1: begin
          q.push_back(GRB | BAOUT | YEN); q.push_back(COUT | ZEN); q.push_back(ZLO | GRA | RIN);
        end
        5'd2: begin
          q.push_back(GRB | BAOUT | YEN); q.push_back(COUT | ZEN); q.push_back(ZLO | MAREN);
          q.push_back(GRA | ROUT | MDREN); q.push_back(WRITE);
        end
        5'd19: begin
          q.push_back(GRA | ROUT | CONIN); q.push_back(PCOUT | YEN); q.push_back(COUT | ZEN);
          q.push_back(con ? (ZLO | PCEN) : 27'h0);
        end
        5'd20: q.push_back(GRA | ROUT | PCEN);
        5'd22: q.push_back(INPOUT | GRA | RIN);
        5'd23: q.push_back(GRA | ROUT | OUTEN);
        5'd24: q.push_back(HIOUT | GRA | RIN);
        5'd25: q.push_back(LOOUT | GRA | RIN);
        default: q.push_back(27'h0);
      endcase
    end
    return q;
  endfunction

  // Model: live = fetching/executing, pos = cycle index within instruction
  bit m_live = 1'b0;
  bit m_halt = 1'b0;
  int m_pos  = 0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_live <= 1'b0;
      m_halt <= 1'b0;
      m_pos  <= 0;
    end else if (!m_live && !m_halt) begin
      m_live <= 1'b1;
      m_pos  <= 0;
    end else if (m_live) begin
      if (m_pos == seq_of(bus.IR[31:27], bus.CON_FF).size() - 1) begin
        m_pos <= 0;
        if (bus.Stop || bus.IR[31:27] == 5'd27) begin
          m_live <= 1'b0;
          m_halt <= 1'b1;
        end
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    wq_t         q;
    logic [26:0] e_ctrl;
    logic [2:0]  e_step;
    q      = seq_of(bus.IR[31:27], bus.CON_FF);
    e_ctrl = m_live ? q[m_pos] : 27'h0;
    e_step = m_live ? 3'(m_pos) : 3'd0;
    checks++;
    if (bus.ctrl !== e_ctrl) begin
      errors++;
      $display("FAIL model_ctrl t=%0t: got %h want %h", $time, bus.ctrl, e_ctrl);
    end
    checks++;
    if (bus.step !== e_step) begin
      errors++;
      $display("FAIL model_step t=%0t: got %0d want %0d", $time, bus.step, e_step);
    end
    checks++;
    if (bus.run !== m_live) begin
      errors++;
      $display("FAIL model_run t=%0t: got %b want %b", $time, bus.run, m_live);
    end
    checks++;
    if ($countones(bus.ctrl & SRC_MASK) > 1) begin
      errors++;
      $display("FAIL bus_exclusive t=%0t: got %h want at most one source", $time, bus.ctrl);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [26:0] cap_ctrl [8];
  logic [2:0]  cap_step [8];
  logic        cap_run  [8];
  logic [2:0]  after_step;
  logic        after_run;

  // Called at posedge+2 with the DUT in fetch T0; returns likewise after len cycles
  task automatic do_instr(input logic [31:0] ir, input logic con, input logic stop, input int len);
    bus.IR     = ir;
    bus.CON_FF = con;
    bus.Stop   = 1'b0;
    for (int t = 0; t < len; t++) begin
      if (stop && t == len - 1) bus.Stop = 1'b1;
      @(negedge clk);
      cap_ctrl[t] = bus.ctrl;
      cap_step[t] = bus.step;
      cap_run[t]  = bus.run;
      @(posedge clk);
      #2;
    end
    bus.Stop   = 1'b0;
    after_step = bus.step;
    after_run  = bus.run;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr        = 1'b0;
    bus.IR     = '0;
    bus.CON_FF = 1'b0;
    bus.Stop   = 1'b0;
    repeat (2) @(negedge clk);
    lit("reset_ctrl", 32'(bus.ctrl), 32'h0);
    lit("reset_run", 32'(bus.run), 32'h0);
    @(posedge clk);
    #2;
    clr = 1'b1;
    @(posedge clk);
    #2;

    // add r5,r2,r4
    do_instr(32'h1A920000, 1'b0, 1'b0, 6);
    lit("fetch_t0_ctrl", 32'(cap_ctrl[0]), 32'h0001054);
    lit("fetch_t0_step", 32'(cap_step[0]), 32'h0);
    lit("fetch_t0_run", 32'(cap_run[0]), 32'h1);
    lit("add_t3", 32'(cap_ctrl[3]), 32'h4800080);
    lit("add_t4", 32'(cap_ctrl[4]), 32'h5000010);
    lit("add_t5", 32'(cap_ctrl[5]), 32'h2404000);
    lit("add_next_step", 32'(after_step), 32'h0);

    // ld
    do_instr(32'h01080000, 1'b0, 1'b0, 8);
    lit("ld_t1_read", 32'(cap_ctrl[1][0]), 32'h1);
    lit("ld_t6_read", 32'(cap_ctrl[6][0]), 32'h1);
    lit("ld_t7", 32'(cap_ctrl[7]), 32'h2420000);
    lit("ld_next_step", 32'(after_step), 32'h0);

    // st
    do_instr(32'h10880000, 1'b0, 1'b0, 8);
    lit("st_t6_read", 32'(cap_ctrl[6][0]), 32'h0);
    lit("st_t7", 32'(cap_ctrl[7]), 32'h0000002);
    for (int t = 0; t < 7; t++) lit("st_no_early_write", 32'(cap_ctrl[t][1]), 32'h0);
    lit("st_next_step", 32'(after_step), 32'h0);

    // br taken / not taken
    do_instr(32'h98800000, 1'b1, 1'b0, 7);
    lit("br_taken_t6", 32'(cap_ctrl[6]), 32'h0004008);
    lit("br_taken_next", 32'(after_step), 32'h0);
    do_instr(32'h98800000, 1'b0, 1'b0, 7);
    lit("br_not_taken_t6", 32'(cap_ctrl[6]), 32'h0);
    lit("br_not_taken_next", 32'(after_step), 32'h0);

    // neg, mul, mfhi, nop
    do_instr(32'h88900000, 1'b0, 1'b0, 5);
    lit("neg_t3", 32'(cap_ctrl[3]), 32'h4800010);
    lit("neg_next_step", 32'(after_step), 32'h0);
    do_instr(32'h78900000, 1'b0, 1'b0, 7);
    lit("mul_t6", 32'(cap_ctrl[6]), 32'h0002100);
    do_instr(32'hC0800000, 1'b0, 1'b0, 4);
    lit("mfhi_t3", 32'(cap_ctrl[3]), 32'h2408000);
    do_instr(32'hD0000000, 1'b0, 1'b0, 4);
    lit("nop_t3", 32'(cap_ctrl[3]), 32'h0);
    lit("nop_next_run", 32'(after_run), 32'h1);

    // Stop during add T5
    do_instr(32'h1A920000, 1'b0, 1'b1, 6);
    lit("stop_halts_run", 32'(after_run), 32'h0);
    repeat (3) @(negedge clk);
    lit("stop_halt_ctrl", 32'(bus.ctrl), 32'h0);
    do_reset();

    // halt opcode
    do_instr(32'hD8000000, 1'b0, 1'b0, 4);
    lit("halt_t3", 32'(cap_ctrl[3]), 32'h0);
    lit("halt_t3_run", 32'(cap_run[3]), 32'h1);
    lit("halt_after_run", 32'(after_run), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lit("halt_hold_ctrl", 32'(bus.ctrl), 32'h0);
      lit("halt_hold_run", 32'(bus.run), 32'h0);
    end
    @(posedge clk);
    #2;
    do_reset();

    // clr pulsed during ld T5
    bus.IR     = 32'h01080000;
    bus.CON_FF = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    lit("mid_ld_step", 32'(bus.step), 32'h5);
    clr = 1'b0;
    #1;
    lit("async_clr_ctrl", 32'(bus.ctrl), 32'h0);
    lit("async_clr_run", 32'(bus.run), 32'h0);
    lit("async_clr_step", 32'(bus.step), 32'h0);
    @(posedge clk);
    #2;
    clr = 1'b1;
    @(posedge clk);
    #2;
    lit("restart_step", 32'(bus.step), 32'h0);
    lit("restart_ctrl", 32'(bus.ctrl), 32'h0001054);
    lit("restart_run", 32'(bus.run), 32'h1);

    // mflo after restart
    do_instr(32'hC8800000, 1'b0, 1'b0, 4);
    lit("mflo_t3", 32'(cap_ctrl[3]), 32'h2410000);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
